// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the FIFO read-side logic.
//   rdr_state_t : burst reader FSM states
//   DEF_WIDTH   : default data word width
//   DEF_DEPTH   : default FIFO depth
//   len_w()     : width of a burst length / word counter able to hold 0..depth
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rdr_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // One extra bit so that a full-depth burst (len == depth) is representable.
    function automatic int len_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// ----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry circular buffer between the FIFO read port and the output stream.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset (clears pointers and occupancy)
//   push       : write push_data this cycle
//   push_data  : word to store
//   pop        : consume the head entry this cycle
//   occ        : number of stored entries, 0..2
//   head_data  : oldest stored entry
// Push and pop in the same cycle are both performed. The caller guarantees
// that it never pushes into a full buffer nor pops an empty one.
// ----------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [width-1:0] head_data
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; occ gates validity,
    // so stale contents are never observed downstream.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
// Read-side master for the synchronous FIFO. Accepts a burst command of N
// words, pops exactly N words from the FIFO and re-presents them on a
// valid/ready stream through a 2-entry skid buffer at one word per cycle.
// Ports:
//   clk, rst       : clock; synchronous active-high reset
//   burst_start    : command strobe, sampled only in IDLE
//   burst_len      : words to read (0..depth), sampled with burst_start
//   burst_busy     : high while a burst is in progress
//   burst_done     : one-cycle completion pulse
//   fifo_read      : FIFO pop request
//   fifo_data_out  : FIFO read data, valid the cycle after an accepted pop
//   fifo_empty     : FIFO empty flag
//   m_data/m_valid : output stream
//   m_ready        : output stream ready from the consumer
// ----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter  int width = DEF_WIDTH,
    parameter  int depth = DEF_DEPTH,
    localparam int LEN_W = len_w(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             burst_busy,
    output logic             burst_done,
    output logic             fifo_read,
    input  logic [width-1:0] fifo_data_out,
    input  logic             fifo_empty,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    rdr_state_t       state, next_state;
    logic [LEN_W-1:0] issue_cnt;    // pops still to be requested from the FIFO
    logic [LEN_W-1:0] out_cnt;      // words still to be handed to the consumer
    logic             rd_pend;      // a pop was issued last cycle; data arrives now
    logic             done_q;
    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       credit;       // skid entries committed after this cycle
    logic             start_ok;
    logic             last_pop;

    assign m_valid  = (occ != 2'd0);
    assign pop      = m_valid && m_ready;
    assign start_ok = (state == IDLE) && burst_start;
    assign last_pop = (state == DRAIN) && pop && (out_cnt == ONE);

    // Words held plus words in flight, minus the one leaving now. Issuing only
    // while this is below 2 means the skid buffer can never overflow, while
    // still allowing one issue per cycle when the consumer keeps up.
    assign credit = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        fifo_read  = 1'b0;
        unique case (state)
            IDLE: begin
                if (burst_start && burst_len != '0) next_state = ISSUE;
            end
            ISSUE: begin
                fifo_read = !fifo_empty && (issue_cnt != '0) && (credit < 3'd2);
                if (fifo_read && issue_cnt == ONE) next_state = DRAIN;
            end
            DRAIN: begin
                if (last_pop) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            out_cnt   <= '0;
            rd_pend   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state   <= next_state;
            rd_pend <= fifo_read;
            done_q  <= (start_ok && burst_len == '0) || last_pop;
            if (start_ok && burst_len != '0) begin
                issue_cnt <= burst_len;
                out_cnt   <= burst_len;
            end else begin
                if (fifo_read && issue_cnt != '0) issue_cnt <= issue_cnt - ONE;
                if (pop && out_cnt != '0)         out_cnt   <= out_cnt - ONE;
            end
        end
    end

    assign burst_busy = (state != IDLE);
    assign burst_done = done_q;

    // A command longer than the FIFO is a caller error.
    a_len_legal: assert property (
        @(posedge clk) disable iff (rst) start_ok |-> (burst_len <= LEN_W'(depth))
    );

    // Reset clears rd_pend, so a word returned from an in-flight pop is dropped.
    fifo_skid_buf #(
        .width(width)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_data(fifo_data_out),
        .pop      (pop),
        .occ      (occ),
        .head_data(m_data)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed bench for fifo_burst_reader with a behavioural FIFO model.
// Inputs are driven 1 time unit after posedge; outputs are read there too,
// and a negedge monitor logs reads, stream transfers and done pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             burst_start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             burst_busy;
    logic             burst_done;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic             fifo_empty;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .width(WIDTH),
        .depth(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .burst_busy   (burst_busy),
        .burst_done   (burst_done),
        .fifo_read    (fifo_read),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    // Behavioural FIFO: writer side owned by the stimulus, reader side here.
    logic [WIDTH-1:0] fmem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_data_out <= fmem[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    // Monitor
    int rd_count       = 0;
    int rd_empty_count = 0;
    int done_count     = 0;
    int rx_n           = 0;
    logic [WIDTH-1:0] rx [0:255];

    always @(negedge clk) begin
        if (fifo_read === 1'b1)                     rd_count       <= rd_count + 1;
        if (fifo_read === 1'b1 && fifo_empty)       rd_empty_count <= rd_empty_count + 1;
        if (burst_done === 1'b1)                    done_count     <= done_count + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            rx[rx_n] <= m_data;
            rx_n     <= rx_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [WIDTH-1:0] v);
        fmem[wr_idx] = v;
        wr_idx       = wr_idx + 1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (burst_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: burst_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", burst_busy); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", burst_done); end
        checks++; if (fifo_read  !== 1'b0) begin failures++; $display("FAIL reset_read: got %b want 0", fifo_read); end
        checks++; if (m_valid    !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int base_rd   = rd_count;
        int base_rx   = rx_n;
        int base_done = done_count;
        logic [WIDTH-1:0] exp [3] = '{16'd7, 16'd8, 16'd9};
        fifo_write(16'd7); fifo_write(16'd8); fifo_write(16'd9);
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 5'd3;          // cycle 0
        step(); burst_start = 1'b0; burst_len = '0;                     // cycle 1
        checks++; if (burst_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_c1: got %b want 1", burst_busy); end
        checks++; if (fifo_read  !== 1'b1) begin failures++; $display("FAIL basic_read_c1: got %b want 1", fifo_read); end
        checks++; if (m_valid    !== 1'b0) begin failures++; $display("FAIL basic_valid_c1: got %b want 0", m_valid); end
        step();                                                         // cycle 2
        checks++; if (m_valid    !== 1'b0) begin failures++; $display("FAIL basic_valid_c2: got %b want 0", m_valid); end
        step();                                                         // cycle 3
        checks++; if (m_valid !== 1'b1 || m_data !== 16'd7) begin failures++; $display("FAIL basic_c3: got v=%b d=%0d want v=1 d=7", m_valid, m_data); end
        step();                                                         // cycle 4
        checks++; if (m_valid !== 1'b1 || m_data !== 16'd8) begin failures++; $display("FAIL basic_c4: got v=%b d=%0d want v=1 d=8", m_valid, m_data); end
        step();                                                         // cycle 5
        checks++; if (m_valid !== 1'b1 || m_data !== 16'd9) begin failures++; $display("FAIL basic_c5: got v=%b d=%0d want v=1 d=9", m_valid, m_data); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL basic_done_early: got %b want 0", burst_done); end
        step();                                                         // cycle 6
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL basic_done_c6: got %b want 1", burst_done); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c6: got %b want 0", burst_busy); end
        checks++; if (m_valid    !== 1'b0) begin failures++; $display("FAIL basic_valid_c6: got %b want 0", m_valid); end
        step();                                                         // cycle 7
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL basic_done_c7: got %b want 0", burst_done); end
        checks++; if (rd_count - base_rd !== 3) begin failures++; $display("FAIL basic_reads: got %0d want 3", rd_count - base_rd); end
        checks++; if (done_count - base_done !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_count - base_done); end
        checks++; if (rx_n - base_rx !== 3) begin failures++; $display("FAIL basic_rx_count: got %0d want 3", rx_n - base_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[base_rx + i] !== exp[i]) begin failures++; $display("FAIL basic_rx[%0d]: got %0d want %0d", i, rx[base_rx + i], exp[i]); end
        end
    endtask

    task automatic test_zero_len();
        int base_rd = rd_count;
        burst_start = 1'b1; burst_len = 5'd0;
        step(); burst_start = 1'b0;
        checks++; if (burst_done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b want 1", burst_done); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b want 0", burst_busy); end
        step();
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b want 0", burst_done); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after: got %b want 0", burst_busy); end
        checks++; if (rd_count - base_rd !== 0) begin failures++; $display("FAIL zero_reads: got %0d want 0", rd_count - base_rd); end
    endtask

    task automatic test_backpressure();
        int base_rd   = rd_count;
        int base_rx   = rx_n;
        int base_done;
        logic [WIDTH-1:0] exp [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        for (int i = 0; i < 4; i++) fifo_write(exp[i]);
        m_ready = 1'b0; burst_start = 1'b1; burst_len = 5'd4;          // cycle 0
        step(); burst_start = 1'b0; burst_len = '0;                     // cycle 1
        step();                                                         // cycle 2
        for (int c = 3; c <= 5; c++) begin
            step();
            checks++; if (m_valid !== 1'b1 || m_data !== 16'h00A1) begin failures++; $display("FAIL bp_hold_c%0d: got v=%b d=%h want v=1 d=00a1", c, m_valid, m_data); end
        end
        checks++; if (rd_count - base_rd !== 2) begin failures++; $display("FAIL bp_reads_stalled: got %0d want 2", rd_count - base_rd); end
        m_ready   = 1'b1;
        base_done = done_count;
        wait_done(20, "bp_done");
        step();
        checks++; if (done_count - base_done !== 1) begin failures++; $display("FAIL bp_done_count: got %0d want 1", done_count - base_done); end
        checks++; if (rd_count - base_rd !== 4) begin failures++; $display("FAIL bp_reads: got %0d want 4", rd_count - base_rd); end
        checks++; if (rx_n - base_rx !== 4) begin failures++; $display("FAIL bp_rx_count: got %0d want 4", rx_n - base_rx); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx[base_rx + i] !== exp[i]) begin failures++; $display("FAIL bp_rx[%0d]: got %h want %h", i, rx[base_rx + i], exp[i]); end
        end
    endtask

    task automatic test_empty_stall();
        int base_rd    = rd_count;
        int base_rx    = rx_n;
        int base_empty = rd_empty_count;
        int n          = 0;
        int written    = 0;
        bit seen       = 1'b0;
        logic [WIDTH-1:0] exp [3] = '{16'h00B0, 16'h00B1, 16'h00B2};
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 5'd3;
        step(); burst_start = 1'b0; burst_len = '0;
        while (!seen && n < 40) begin
            if (n % 3 == 0 && written < 3) begin
                fifo_write(exp[written]);
                written++;
            end
            step();
            n++;
            if (burst_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL stall_done: not seen within 40 cycles"); end
        step();
        checks++; if (rd_empty_count - base_empty !== 0) begin failures++; $display("FAIL stall_read_empty: got %0d want 0", rd_empty_count - base_empty); end
        checks++; if (rd_count - base_rd !== 3) begin failures++; $display("FAIL stall_reads: got %0d want 3", rd_count - base_rd); end
        checks++; if (rx_n - base_rx !== 3) begin failures++; $display("FAIL stall_rx_count: got %0d want 3", rx_n - base_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[base_rx + i] !== exp[i]) begin failures++; $display("FAIL stall_rx[%0d]: got %h want %h", i, rx[base_rx + i], exp[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int base_rd   = rd_count;
        int base_rx   = rx_n;
        int base_done = done_count;
        logic [WIDTH-1:0] exp [3] = '{16'h00C1, 16'h00C2, 16'h00C3};
        for (int i = 0; i < 3; i++) fifo_write(exp[i]);
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 5'd3;          // cycle 0
        step(); burst_start = 1'b0; burst_len = '0;                     // cycle 1
        step(); burst_start = 1'b1; burst_len = 5'd5;                   // cycle 2, in ISSUE
        step(); burst_start = 1'b0; burst_len = '0;
        wait_done(20, "ign_done");
        step(); step(); step();
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL ign_busy: got %b want 0", burst_busy); end
        checks++; if (done_count - base_done !== 1) begin failures++; $display("FAIL ign_done_count: got %0d want 1", done_count - base_done); end
        checks++; if (rd_count - base_rd !== 3) begin failures++; $display("FAIL ign_reads: got %0d want 3", rd_count - base_rd); end
        checks++; if (rx_n - base_rx !== 3) begin failures++; $display("FAIL ign_rx_count: got %0d want 3", rx_n - base_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[base_rx + i] !== exp[i]) begin failures++; $display("FAIL ign_rx[%0d]: got %h want %h", i, rx[base_rx + i], exp[i]); end
        end
    endtask

    task automatic test_reset_drain();
        int base_done = done_count;
        int base_rd;
        int base_rx;
        logic [WIDTH-1:0] exp [3] = '{16'h00D3, 16'h00E1, 16'h00E2};
        fifo_write(16'h00D1); fifo_write(16'h00D2); fifo_write(16'h00D3);
        m_ready = 1'b0; burst_start = 1'b1; burst_len = 5'd2;          // cycle 0
        step(); burst_start = 1'b0; burst_len = '0;                     // cycle 1
        step(); step(); step();                                         // cycle 4: DRAIN, occ=2
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h00D1 || burst_busy !== 1'b1) begin failures++; $display("FAIL rstd_pre: got v=%b d=%h busy=%b want v=1 d=00d1 busy=1", m_valid, m_data, burst_busy); end
        rst = 1'b1;
        step();
        checks++; if (m_valid    !== 1'b0) begin failures++; $display("FAIL rstd_valid: got %b want 0", m_valid); end
        checks++; if (burst_busy !== 1'b0) begin failures++; $display("FAIL rstd_busy: got %b want 0", burst_busy); end
        checks++; if (burst_done !== 1'b0) begin failures++; $display("FAIL rstd_done: got %b want 0", burst_done); end
        rst = 1'b0;
        step(); step(); step();
        checks++; if (done_count - base_done !== 0) begin failures++; $display("FAIL rstd_no_done: got %0d want 0", done_count - base_done); end
        // Fresh burst: the untouched third word followed by two new ones.
        base_rd = rd_count;
        base_rx = rx_n;
        fifo_write(16'h00E1); fifo_write(16'h00E2);
        m_ready = 1'b1; burst_start = 1'b1; burst_len = 5'd3;
        step(); burst_start = 1'b0; burst_len = '0;
        wait_done(20, "rstd_fresh_done");
        step();
        checks++; if (rd_count - base_rd !== 3) begin failures++; $display("FAIL rstd_reads: got %0d want 3", rd_count - base_rd); end
        checks++; if (rx_n - base_rx !== 3) begin failures++; $display("FAIL rstd_rx_count: got %0d want 3", rx_n - base_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[base_rx + i] !== exp[i]) begin failures++; $display("FAIL rstd_rx[%0d]: got %h want %h", i, rx[base_rx + i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_empty_stall();
        test_ignore_start();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for the team's synchronous FIFO (`dut`). It accepts a burst command of N words and pops exactly N words through the FIFO's `fifo_read`/`fifo_data_out`/`fifo_empty` port. It re-presents those words on a valid/ready stream through a 2-entry skid buffer, sustaining one word per cycle. It reports completion with a one-cycle `burst_done` pulse.

## Interface
- `width`, 16, data word width; equals the FIFO's `width`.
- `depth`, 16, FIFO depth; sets `LEN_W = $clog2(depth)+1`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `burst_start`  in  1  command strobe; sampled only in IDLE.
- `burst_len`  in  LEN_W  words to read, 0..depth; sampled with `burst_start`.
- `burst_busy`  out  1  high while a burst is in progress.
- `burst_done`  out  1  one-cycle completion pulse.
- `fifo_read`  out  1  FIFO pop request.
- `fifo_data_out`  in  width  FIFO read data; valid the cycle after an accepted pop.
- `fifo_empty`  in  1  FIFO empty flag.
- `m_data`  out  width  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the consumer.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `burst_start` with `burst_len==0`: `burst_done` pulses next cycle; stay in IDLE.
  - `burst_start` with `burst_len!=0`: load `issue_cnt = burst_len` and `out_cnt = burst_len`; go to ISSUE.
- ISSUE: `fifo_read = !fifo_empty && issue_cnt!=0 && (occ + rd_pend - pop) < 2`.
  - `occ` is the skid occupancy (0..2).
  - `rd_pend` is `fifo_read` registered.
  - `pop = m_valid && m_ready`.
  - Each asserted `fifo_read` decrements `issue_cnt`.
  - Go to DRAIN in the cycle `issue_cnt` reaches 0.
- DRAIN: `fifo_read = 0`. Each `pop` decrements `out_cnt`. The pop that takes `out_cnt` 1->0 moves the FSM to IDLE and registers `burst_done`.
- `out_cnt` also decrements on pops during ISSUE.
- `fifo_read` is never asserted while `fifo_empty=1`. No pop ever targets an empty FIFO.
- Skid buffer:
  - Pushes `fifo_data_out` when `rd_pend=1`.
  - `m_valid = occ!=0`; `m_data` is the oldest entry (FIFO order).
  - Push and pop in the same cycle are both performed.
  - The credit rule makes overflow impossible.
- `burst_start` outside IDLE is ignored.
- `burst_len > depth` is illegal; behaviour is unspecified, and an assertion flags it.
- Counters are LEN_W bits wide and never wrap: decrements are gated on `!=0`.

## Timing
- Reset values (cycle after `rst` sampled high): state=IDLE, `burst_busy=0`, `burst_done=0`, `fifo_read=0`, `m_valid=0`, `rd_pend=0`, `occ=0`, counters=0.
- Reset mid-burst aborts the burst with no `burst_done`. Any data from an in-flight pop is discarded.
- `fifo_read` is combinational from registered state, `fifo_empty` and `m_ready`.
- `burst_busy` rises the cycle after an accepted `burst_start` with nonzero length. It falls in the same cycle `burst_done` is high.
- Latency: `burst_start` at cycle 0 -> first `fifo_read` at cycle 1 (FIFO non-empty) -> `m_valid` at cycle 3.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle.
- Last pop at cycle t -> `burst_done=1` at t+1. A new `burst_start` is accepted at t+1.
- `m_data` is stable while `m_valid && !m_ready`.
- `fifo_empty` rising mid-burst stalls issue with no bubble corruption. Issue resumes the cycle `fifo_empty` falls.

## Structure
- Package `fifo_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rdr_state_t`.
  - Default `width`/`depth` constants.
  - Helper `len_w(depth)`.
- Sub-module `fifo_skid_buf #(width)`: 2-entry buffer exposing `push`, `push_data`, `pop`, `occ`, head data.
- The FSM and counters live in `fifo_burst_reader`.

## Test plan
- FIFO preloaded with 7,8,9; `burst_len=3`; `m_ready=1` -> `m_data` 7,8,9 on consecutive cycles; three `fifo_read` pulses; `burst_done` one cycle after the last pop.
- `burst_len=0` -> `burst_done` pulse next cycle; `burst_busy` stays 0; no `fifo_read`.
- `burst_len=4`, `m_ready=0` for 5 cycles -> exactly 2 `fifo_read`s issued; `m_data=first word` held stable. Release `m_ready` -> all 4 words in order, then `burst_done`.
- FIFO empty at start, one word written every 3 cycles, `burst_len=3` -> `fifo_read` only when `fifo_empty=0`; 3 words delivered; no read while empty.
- `burst_start` pulsed again during ISSUE with `burst_len=5` -> ignored; the original burst's word count completes.
- `rst` asserted in DRAIN with `occ=2` -> next cycle `m_valid=0`, `burst_busy=0`, no `burst_done`; a fresh burst afterwards operates normally.
